// File: rtl/comp_status_reg_if.sv
// Comparator verdict handshake plus Avalon-MM slave bus for the comparator status block.
interface comp_status_reg_if #(
    parameter int unsigned KEY_WIDTH = 4
);
    // Comparator side
    logic                 comp_status_write;
    logic [KEY_WIDTH-1:0] comp_task;
    logic                 comp_mismatch_detected;
    logic                 comp_status_ack;
    // Monitor CPU side
    logic [2:0]           avs_address;
    logic                 avs_read;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic [31:0]          avs_readdata;
    logic                 irq;

    modport master (
        output comp_status_write, comp_task, comp_mismatch_detected,
        output avs_address, avs_read, avs_write, avs_writedata,
        input  comp_status_ack, avs_readdata, irq
    );

    modport slave (
        input  comp_status_write, comp_task, comp_mismatch_detected,
        input  avs_address, avs_read, avs_write, avs_writedata,
        output comp_status_ack, avs_readdata, irq
    );
endinterface

// File: rtl/comp_status_reg.sv
// Records comparator verdicts into sticky pass/fail masks and an event FIFO, and exposes
// them to the monitor CPU over an Avalon-MM slave with a level interrupt.
module comp_status_reg #(
    parameter int unsigned KEY_WIDTH  = 4,
    parameter int unsigned KEY_SIZE   = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input logic              clk,
    input logic              reset,
    comp_status_reg_if.slave bus
);

    localparam int unsigned EntryW = KEY_WIDTH + 1;
    localparam logic [FIFO_AW:0] FullCount = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e               state_q, state_d;
    logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count;
    logic                 fifo_full, fifo_empty, push, pop, stall_set;
    logic [EntryW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [EntryW-1:0]    head;
    logic [KEY_SIZE-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic [1:0]           irq_en_q, irq_en_d;
    logic                 stall_q, stall_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;
    logic                 wr_clear, wr_irq_en, wr_fstat;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (count == FullCount);
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

    assign pop       = bus.avs_read && (bus.avs_address == 3'd2) && !fifo_empty;
    assign wr_clear  = bus.avs_write && (bus.avs_address == 3'd4);
    assign wr_irq_en = bus.avs_write && (bus.avs_address == 3'd3);
    assign wr_fstat  = bus.avs_write && (bus.avs_address == 3'd5);

    // Ack comes straight from the state register so an async reset drops it at once.
    assign bus.comp_status_ack = (state_q == StAck);
    assign bus.avs_readdata    = rdata_q;
    assign bus.irq             = irq_q;

    // Handshake FSM: write is sampled only in idle, so a held write is never captured twice.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        stall_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.comp_status_write) begin
                    if (!fifo_full) begin
                        state_d = StAck;
                    end else begin
                        stall_set = 1'b1;
                    end
                end
            end
            StAck: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Pointer, mask and control next-state; an ack on a bit beats a same-cycle clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        pass_d   = pass_q;
        fail_d   = fail_q;
        irq_en_d = irq_en_q;
        stall_d  = stall_q;
        if (wr_clear) begin
            pass_d = pass_q & ~bus.avs_writedata[KEY_SIZE-1:0];
            fail_d = fail_q & ~bus.avs_writedata[16 +: KEY_SIZE];
        end
        if (push) begin
            if (bus.comp_mismatch_detected) begin
                fail_d[bus.comp_task] = 1'b1;
                pass_d[bus.comp_task] = 1'b0;
            end else begin
                pass_d[bus.comp_task] = 1'b1;
                fail_d[bus.comp_task] = 1'b0;
            end
        end
        if (wr_irq_en) begin
            irq_en_d = bus.avs_writedata[1:0];
        end
        if (wr_fstat && bus.avs_writedata[16]) begin
            stall_d = 1'b0;
        end
        if (stall_set) begin
            stall_d = 1'b1;
        end
        irq_d = (irq_en_q[0] && !fifo_empty) || (irq_en_q[1] && (|fail_q));
    end

    // Read mux; the value is registered so it appears the cycle after the strobe.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.avs_read) begin
            rdata_d = '0;
            case (bus.avs_address)
                3'd0: rdata_d[KEY_SIZE-1:0] = pass_q;
                3'd1: rdata_d[KEY_SIZE-1:0] = fail_q;
                3'd2: begin
                    if (!fifo_empty) begin
                        rdata_d[31]            = 1'b1;
                        rdata_d[8]             = head[KEY_WIDTH];
                        rdata_d[KEY_WIDTH-1:0] = head[KEY_WIDTH-1:0];
                    end
                end
                3'd3: rdata_d[1:0] = irq_en_q;
                3'd5: begin
                    rdata_d[FIFO_AW:0] = count;
                    rdata_d[16]        = stall_q;
                end
                default: ;
            endcase
        end
    end

    // FIFO storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= {bus.comp_mismatch_detected, bus.comp_task};
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            irq_en_q <= '0;
            stall_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            irq_en_q <= irq_en_d;
            stall_q  <= stall_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_comp_status_reg.sv
// Scoreboard bench for comp_status_reg: reads queue their expected data, a monitor checks it.
module tb_comp_status_reg;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic rd_valid_q;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [4:0]  model_q[$];

    comp_status_reg_if #(.KEY_WIDTH(4)) bus ();

    comp_status_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track which cycles carry read data.
    always @(posedge clk or posedge reset) begin
        if (reset) rd_valid_q <= 1'b0;
        else       rd_valid_q <= bus.avs_read;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare read data against the scoreboard whenever it is presented.
    always @(negedge clk) begin
        if (rd_valid_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", bus.avs_readdata, 32'hdead_beef);
            end else begin
                check(name_q.pop_front(), bus.avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [2:0] addr, input logic [31:0] data);
        bus.avs_write     = 1'b1;
        bus.avs_address   = addr;
        bus.avs_writedata = data;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus.avs_read    = 1'b1;
        bus.avs_address = addr;
        tick();
        bus.avs_read    = 1'b0;
    endtask

    function automatic logic [31:0] ev_word(input logic [4:0] e);
        return 32'h8000_0000 | (32'(e[4]) << 8) | 32'(e[3:0]);
    endfunction

    task automatic ev_read_model(input string name);
        logic [31:0] exp;
        exp = 32'h0;
        if (model_q.size() != 0) exp = ev_word(model_q.pop_front());
        avs_rd(3'd2, exp, name);
    endtask

    // Present one verdict, expect ack exactly one cycle later and for one cycle only.
    task automatic issue(input logic [3:0] t, input logic mm);
        int lat;
        lat = 0;
        bus.comp_status_write      = 1'b1;
        bus.comp_task              = t;
        bus.comp_mismatch_detected = mm;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (bus.comp_status_ack) begin
                lat = i;
                break;
            end
        end
        bus.comp_status_write = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
        tick();
        check("ack_single", 32'(bus.comp_status_ack), 32'd0);
        if (lat != 0) model_q.push_back({mm, t});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.comp_status_write      = 1'b0;
        bus.comp_task              = '0;
        bus.comp_mismatch_detected = 1'b0;
        bus.avs_address            = '0;
        bus.avs_read               = 1'b0;
        bus.avs_write              = 1'b0;
        bus.avs_writedata          = '0;
        #1;
        check("reset_ack", 32'(bus.comp_status_ack), 32'd0);
        check("reset_rdata", bus.avs_readdata, 32'h0);
        check("reset_irq", 32'(bus.irq), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 1: single pass verdict
        issue(4'd3, 1'b0);
        avs_rd(3'd0, 32'h0000_0008, "t1_pass");
        avs_rd(3'd1, 32'h0000_0000, "t1_fail");
        avs_rd(3'd2, 32'h8000_0003, "t1_event");
        avs_rd(3'd5, 32'h0000_0000, "t1_fstat");

        // 2: fail verdict raises irq, clearing the fail bit lowers it
        avs_wr(3'd3, 32'h2);
        avs_rd(3'd3, 32'h2, "t2_irq_en");
        issue(4'd5, 1'b1);
        avs_rd(3'd1, 32'h0000_0020, "t2_fail");
        check("t2_irq_set", 32'(bus.irq), 32'd1);
        avs_wr(3'd4, 32'h0020_0000);
        tick();
        check("t2_irq_clr", 32'(bus.irq), 32'd0);
        avs_rd(3'd1, 32'h0000_0000, "t2_fail_clr");
        avs_rd(3'd0, 32'h0000_0008, "t2_pass_kept");
        avs_rd(3'd4, 32'h0000_0000, "t2_clear_reads0");
        avs_rd(3'd2, 32'h8000_0105, "t2_event");
        avs_wr(3'd3, 32'h0);

        // 3: fill FIFO, ninth verdict stalls until one pop
        for (int i = 0; i < 8; i++) issue(4'(i), 1'(i % 2));
        avs_rd(3'd5, 32'h0000_0008, "t3_fstat_full");
        bus.comp_status_write      = 1'b1;
        bus.comp_task              = 4'd8;
        bus.comp_mismatch_detected = 1'b0;
        got = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.comp_status_ack) got = 1;
        end
        check("t3_no_ack_full", 32'(got), 32'd0);
        avs_rd(3'd5, 32'h0001_0008, "t3_fstat_stall");
        avs_rd(3'd2, 32'h8000_0000, "t3_pop0");
        got = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.comp_status_ack) begin
                got = 1;
                break;
            end
            tick();
        end
        check("t3_ack_after_pop", 32'(got), 32'd1);
        bus.comp_status_write = 1'b0;
        tick();
        avs_wr(3'd5, 32'h0001_0000);
        avs_rd(3'd5, 32'h0000_0008, "t3_fstat_w1c");
        avs_rd(3'd2, 32'h8000_0101, "t3_ev1");
        avs_rd(3'd2, 32'h8000_0002, "t3_ev2");
        avs_rd(3'd2, 32'h8000_0103, "t3_ev3");
        avs_rd(3'd2, 32'h8000_0004, "t3_ev4");
        avs_rd(3'd2, 32'h8000_0105, "t3_ev5");
        avs_rd(3'd2, 32'h8000_0006, "t3_ev6");
        avs_rd(3'd2, 32'h8000_0107, "t3_ev7");
        avs_rd(3'd2, 32'h8000_0008, "t3_ev8");
        avs_rd(3'd0, 32'h0000_0155, "t3_pass");
        avs_rd(3'd1, 32'h0000_00aa, "t3_fail");

        // 4: empty FIFO read
        avs_rd(3'd2, 32'h0000_0000, "t4_event_empty");
        avs_rd(3'd5, 32'h0000_0000, "t4_fstat_empty");
        avs_wr(3'd3, 32'h1);
        tick();
        tick();
        check("t4_irq_empty", 32'(bus.irq), 32'd0);

        // 5: concurrent pop and push at count 4, then stream across pointer wrap
        model_q.delete();
        for (int i = 10; i < 14; i++) issue(4'(i), 1'b0);
        bus.comp_status_write      = 1'b1;
        bus.comp_task              = 4'd14;
        bus.comp_mismatch_detected = 1'b1;
        tick();
        check("t5_ack_conc", 32'(bus.comp_status_ack), 32'd1);
        bus.comp_status_write = 1'b0;
        ev_read_model("t5_pop_conc");
        model_q.push_back({1'b1, 4'd14});
        check("t5_ack_conc_single", 32'(bus.comp_status_ack), 32'd0);
        avs_rd(3'd5, 32'h0000_0004, "t5_fstat_conc");
        for (int k = 0; k < 12; k++) begin
            issue(4'(k), 1'(k % 2));
            ev_read_model("t5_stream");
        end
        for (int k = 0; k < 4; k++) ev_read_model("t5_drain");
        avs_rd(3'd5, 32'h0000_0000, "t5_fstat_end");

        // 6: reset during ack
        issue(4'd9, 1'b0);
        tick();
        check("t6_irq_pre", 32'(bus.irq), 32'd1);
        bus.comp_status_write = 1'b1;
        bus.comp_task         = 4'd2;
        tick();
        check("t6_ack_pre", 32'(bus.comp_status_ack), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_ack_drop", 32'(bus.comp_status_ack), 32'd0);
        check("t6_irq_reset", 32'(bus.irq), 32'd0);
        bus.comp_status_write = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        avs_rd(3'd0, 32'h0, "t6_pass");
        avs_rd(3'd1, 32'h0, "t6_fail");
        avs_rd(3'd5, 32'h0, "t6_fstat");
        avs_rd(3'd2, 32'h0, "t6_event");
        avs_rd(3'd3, 32'h0, "t6_irq_en");
        tick();
        check("t6_irq_post", 32'(bus.irq), 32'd0);
        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
